// File: rtl/t5_pkg.sv
// Shared definitions for the t5 hart scheduler: hart count, hart-state
// encoding, default start address and a one-hot to index helper.
package t5_pkg;

    localparam int HARTS  = 4;
    localparam int HART_W = 2;

    localparam logic [31:0] DEF_RESET_PC = 32'h0;

    typedef enum logic [1:0] {
        HS_IDLE = 2'b00,
        HS_RUN  = 2'b01,
        HS_WAIT = 2'b10
    } hart_state_e;

    function automatic logic [HART_W-1:0] onehot_to_idx(input logic [HARTS-1:0] oh);
        logic [HART_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < HARTS; i++) begin
            if (oh[i]) begin
                idx = HART_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/t5_rrarb.sv
// 4-way round-robin arbiter: the search starts at the hart after the last
// grant and wraps, so the last granted hart has the lowest priority.
module t5_rrarb
    import t5_pkg::*;
(
    input  logic [HARTS-1:0]  req,
    input  logic [HART_W-1:0] last,
    output logic [HARTS-1:0]  gnt,
    output logic              vld
);

    logic [HARTS-1:0]  rot_req;
    logic [HART_W-1:0] ofs;
    logic [HART_W-1:0] gnt_idx;

    // rot_req[k] is the request of hart (last + 1 + k) mod HARTS
    genvar gi;
    generate
        for (gi = 0; gi < HARTS; gi++) begin : g_rot
            logic [HART_W-1:0] idx;
            assign idx         = last + HART_W'(gi + 1);
            assign rot_req[gi] = req[idx];
        end
    endgenerate

    always_comb begin
        ofs = '0;
        for (int i = HARTS - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                ofs = HART_W'(i);
            end
        end
    end

    assign gnt_idx = last + ofs + HART_W'(1);
    assign vld     = |req;
    assign gnt     = vld ? (HARTS'(1) << gnt_idx) : '0;

endmodule

// File: rtl/t5_hsch.sv
// Barrel-style hart scheduler: per-hart PC and IDLE/RUN/WAIT state, one
// fetch slot per enabled cycle. Define T5_HSCH_SKIP_EN for work-conserving
// selection; otherwise slots rotate strictly 0,1,2,3.
module t5_hsch
    import t5_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEF_RESET_PC)
) (
    input  logic                sclk,
    input  logic                srst,
    input  logic                sena,
    input  logic [HARTS-1:0]    hen,
    input  logic [HARTS-1:0]    hwait,
    input  logic [HARTS-1:0]    hrel,
    input  logic                xbra,
    input  logic [XLEN-1:0]     xtgt,
    output logic [XLEN-1:0]     fpc,
    output logic                fvld,
    output logic [2*HARTS-1:0]  hstat
);

    localparam logic [XLEN-3:0] RESET_WPC = RESET_PC[XLEN-1:2];

    logic [HARTS-1:0][XLEN-3:0] pc_vec;
    logic [HARTS-1:0][1:0]      st_vec;
    logic [HARTS-1:0]           elig;
    logic [HARTS-1:0]           arb_req;
    logic [HARTS-1:0]           arb_gnt;
    logic                       arb_vld;
    logic [HART_W-1:0]          sel;
    logic                       issue;

    logic [HART_W-1:0]          last_q, last_d;
    logic [XLEN-1:0]            fpc_q, fpc_d;
    logic                       fvld_q, fvld_d;

    genvar gi;
    generate
        for (gi = 0; gi < HARTS; gi++) begin : g_hart
            hart_state_e     state_q, state_d;
            logic [XLEN-3:0] pc_q, pc_d;

            always_comb begin
                state_d = state_q;
                pc_d    = pc_q;
                if (sena) begin
                    if (!hen[gi]) begin
                        state_d = HS_IDLE;
                    end else begin
                        case (state_q)
                            HS_IDLE: begin
                                state_d = HS_RUN;
                                pc_d    = RESET_WPC;
                            end
                            HS_RUN:  if (hwait[gi]) state_d = HS_WAIT;
                            HS_WAIT: if (!hwait[gi] && hrel[gi]) state_d = HS_RUN;
                            default: state_d = HS_IDLE;
                        endcase
                    end
                    if (issue && (sel == HART_W'(gi))) begin
                        pc_d = pc_q + (XLEN-2)'(1);
                    end
                    // a redirect overrides the issue increment; IDLE harts ignore it
                    if (xbra && (xtgt[1:0] == HART_W'(gi)) && (state_q != HS_IDLE)) begin
                        pc_d = xtgt[XLEN-1:2];
                    end
                end
            end

            always_ff @(posedge sclk) begin
                if (srst) begin
                    state_q <= (gi == 0) ? HS_RUN : HS_IDLE;
                    pc_q    <= RESET_WPC;
                end else begin
                    state_q <= state_d;
                    pc_q    <= pc_d;
                end
            end

            assign pc_vec[gi] = pc_q;
            assign st_vec[gi] = state_q;
            assign elig[gi]   = (state_q == HS_RUN);
        end
    endgenerate

    // strict rotation requests every slot and lets fvld mark the idle ones
`ifdef T5_HSCH_SKIP_EN
    assign arb_req = elig;
`else
    assign arb_req = '1;
`endif

    t5_rrarb u_rrarb (
        .req  (arb_req),
        .last (last_q),
        .gnt  (arb_gnt),
        .vld  (arb_vld)
    );

    assign sel   = onehot_to_idx(arb_gnt);
    assign issue = arb_vld && elig[sel];

    always_comb begin
        last_d = last_q;
        fpc_d  = fpc_q;
        fvld_d = fvld_q;
        if (sena) begin
            fvld_d = issue;
            if (arb_vld) begin
                last_d = sel;
                fpc_d  = {pc_vec[sel], sel};
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            last_q <= HART_W'(HARTS - 1);
            fpc_q  <= '0;
            fvld_q <= 1'b0;
        end else begin
            last_q <= last_d;
            fpc_q  <= fpc_d;
            fvld_q <= fvld_d;
        end
    end

    assign fpc   = fpc_q;
    assign fvld  = fvld_q;
    assign hstat = st_vec;

endmodule

// File: tb/tb_t5_hsch.sv
// Directed bench for t5_hsch: a vector table with per-build expectations,
// plus hand-written redirect and enable-freeze/reset sequences.
module tb_t5_hsch;

    logic        sclk = 1'b0;
    logic        srst;
    logic        sena;
    logic [3:0]  hen;
    logic [3:0]  hwait;
    logic [3:0]  hrel;
    logic        xbra;
    logic [31:0] xtgt;
    logic [31:0] fpc;
    logic        fvld;
    logic [7:0]  hstat;

    int n_checks = 0;
    int n_errors = 0;

    always #5 sclk = ~sclk;

    t5_hsch #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .sclk  (sclk),
        .srst  (srst),
        .sena  (sena),
        .hen   (hen),
        .hwait (hwait),
        .hrel  (hrel),
        .xbra  (xbra),
        .xtgt  (xtgt),
        .fpc   (fpc),
        .fvld  (fvld),
        .hstat (hstat)
    );

    typedef struct {
        logic        rst;
        logic        ena;
        logic [3:0]  hen;
        logic [3:0]  hwait;
        logic [3:0]  hrel;
        logic [31:0] fpc;
        logic        fvld;
        logic [7:0]  hstat;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic ena, input logic [3:0] h_en,
                       input logic [3:0] h_wait, input logic [3:0] h_rel,
                       input logic [31:0] fpc_strict, input logic fvld_strict,
                       input logic [31:0] fpc_skip, input logic fvld_skip,
                       input logic [7:0] hs);
        vec_t v;
        v.rst   = rst;
        v.ena   = ena;
        v.hen   = h_en;
        v.hwait = h_wait;
        v.hrel  = h_rel;
`ifdef T5_HSCH_SKIP_EN
        v.fpc   = fpc_skip;
        v.fvld  = fvld_skip;
`else
        v.fpc   = fpc_strict;
        v.fvld  = fvld_strict;
`endif
        v.hstat = hs;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // drive one cycle of inputs, then sample just after the rising edge
    task automatic step(input logic rst, input logic ena, input logic [3:0] h_en,
                        input logic [3:0] h_wait, input logic [3:0] h_rel,
                        input logic br, input logic [31:0] tgt);
        srst  = rst;
        sena  = ena;
        hen   = h_en;
        hwait = h_wait;
        hrel  = h_rel;
        xbra  = br;
        xtgt  = tgt;
        @(posedge sclk);
        #1;
    endtask

    task automatic check_all(input string name, input int idx, input logic [31:0] e_fpc,
                             input logic e_fvld, input logic [7:0] e_hstat);
        $display("%s %0d: fpc=0x%0h fvld=%0d hstat=0x%02h", name, idx, fpc, fvld, hstat);
        check({name, ".fpc"}, idx, fpc, e_fpc);
        check({name, ".fvld"}, idx, 32'(fvld), 32'(e_fvld));
        check({name, ".hstat"}, idx, 32'(hstat), 32'(e_hstat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd_fpc[10];

        srst = 1'b1; sena = 1'b0; hen = '0; hwait = '0; hrel = '0;
        xbra = 1'b0; xtgt = '0;

        //   rst ena hen   hwait  hrel   strict fpc,fvld  skip fpc,fvld  hstat
        add(1, 0, 4'h0, 4'h0, 4'h0, 32'h0,  0, 32'h0,  0, 8'h01);
        add(0, 1, 4'hF, 4'h0, 4'h0, 32'h0,  1, 32'h0,  1, 8'h55);
        add(0, 1, 4'hF, 4'h0, 4'h0, 32'h1,  1, 32'h1,  1, 8'h55);
        add(0, 1, 4'hF, 4'h0, 4'h0, 32'h2,  1, 32'h2,  1, 8'h55);
        add(0, 1, 4'hF, 4'h0, 4'h0, 32'h3,  1, 32'h3,  1, 8'h55);
        add(0, 1, 4'hF, 4'h0, 4'h0, 32'h4,  1, 32'h4,  1, 8'h55);
        add(0, 1, 4'hF, 4'h0, 4'h0, 32'h5,  1, 32'h5,  1, 8'h55);
        add(0, 1, 4'hF, 4'h4, 4'h0, 32'h6,  1, 32'h6,  1, 8'h65);
        add(0, 1, 4'hF, 4'h0, 4'h0, 32'h7,  1, 32'h7,  1, 8'h65);
        add(0, 1, 4'hF, 4'h0, 4'h0, 32'h8,  1, 32'h8,  1, 8'h65);
        add(0, 1, 4'hF, 4'h0, 4'h0, 32'h9,  1, 32'h9,  1, 8'h65);
        add(0, 1, 4'hF, 4'h0, 4'h0, 32'hA,  0, 32'hB,  1, 8'h65);
        add(0, 1, 4'hF, 4'h0, 4'h4, 32'hB,  1, 32'hC,  1, 8'h55);
        add(0, 1, 4'hF, 4'h0, 4'h0, 32'hC,  1, 32'hD,  1, 8'h55);
        add(0, 1, 4'hF, 4'h0, 4'h0, 32'hD,  1, 32'hA,  1, 8'h55);
        add(0, 1, 4'hF, 4'h0, 4'h0, 32'hA,  1, 32'hF,  1, 8'h55);
        add(0, 1, 4'hF, 4'h8, 4'h0, 32'hF,  1, 32'h10, 1, 8'h95);
        add(0, 1, 4'hF, 4'h8, 4'h8, 32'h10, 1, 32'h11, 1, 8'h95);
        add(0, 1, 4'hF, 4'h0, 4'h8, 32'h11, 1, 32'hE,  1, 8'h55);
        // second run: harts 0 and 2, hart 0 disabled and re-enabled, then all off
        add(1, 1, 4'h5, 4'h0, 4'h0, 32'h0,  0, 32'h0,  0, 8'h01);
        add(0, 1, 4'h5, 4'h0, 4'h0, 32'h0,  1, 32'h0,  1, 8'h11);
        add(0, 1, 4'h5, 4'h0, 4'h0, 32'h1,  0, 32'h2,  1, 8'h11);
        add(0, 1, 4'h5, 4'h0, 4'h0, 32'h2,  1, 32'h4,  1, 8'h11);
        add(0, 1, 4'h5, 4'h0, 4'h0, 32'h3,  0, 32'h6,  1, 8'h11);
        add(0, 1, 4'h5, 4'h0, 4'h0, 32'h4,  1, 32'h8,  1, 8'h11);
        add(0, 1, 4'h4, 4'h1, 4'h0, 32'h1,  0, 32'hA,  1, 8'h10);
        add(0, 1, 4'h4, 4'h0, 4'h0, 32'h6,  1, 32'hE,  1, 8'h10);
        add(0, 1, 4'h4, 4'h0, 4'h0, 32'h3,  0, 32'h12, 1, 8'h10);
        add(0, 1, 4'h4, 4'h0, 4'h0, 32'h8,  0, 32'h16, 1, 8'h10);
        add(0, 1, 4'h5, 4'h0, 4'h0, 32'h1,  0, 32'h1A, 1, 8'h11);
        add(0, 1, 4'h5, 4'h0, 4'h0, 32'hA,  1, 32'h0,  1, 8'h11);
        add(0, 1, 4'h5, 4'h0, 4'h0, 32'h3,  0, 32'h1E, 1, 8'h11);
        add(0, 1, 4'h5, 4'h0, 4'h0, 32'h0,  1, 32'h4,  1, 8'h11);
        add(0, 1, 4'h0, 4'h0, 4'h0, 32'h1,  0, 32'h22, 1, 8'h00);
        add(0, 1, 4'h0, 4'h0, 4'h0, 32'hE,  0, 32'h22, 0, 8'h00);
        add(0, 1, 4'h0, 4'h0, 4'h0, 32'h3,  0, 32'h22, 0, 8'h00);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].ena, vecs[i].hen, vecs[i].hwait, vecs[i].hrel, 1'b0, 32'h0);
            check_all("vec", i, vecs[i].fpc, vecs[i].fvld, vecs[i].hstat);
        end

        // redirect hart 1 to 0x1001 in the cycle it issues
        rd_fpc = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h1001, 32'h6, 32'h7, 32'h8, 32'h1005};
        step(1, 1, 4'hF, 4'h0, 4'h0, 1'b0, 32'h0);
        check_all("redir_rst", 0, 32'h0, 1'b0, 8'h01);
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 4'hF, 4'h0, 4'h0, (k == 1), 32'h0000_1001);
            check_all("redir", k, rd_fpc[k], 1'b1, 8'h55);
        end

        // enable low: every input ignored, outputs frozen
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 4'h0, 4'hF, 4'h0, 1'b1, 32'h0000_0042);
            check_all("freeze", k, 32'h1005, 1'b1, 8'h55);
        end
        // reset while frozen and mid-stall request
        step(1, 0, 4'h0, 4'hF, 4'h0, 1'b1, 32'h0000_0042);
        check_all("frz_rst", 0, 32'h0, 1'b0, 8'h01);
        step(0, 1, 4'hF, 4'h0, 4'h0, 1'b0, 32'h0);
        check_all("post_rst", 0, 32'h0, 1'b1, 8'h55);
        step(0, 1, 4'hF, 4'h0, 4'h0, 1'b0, 32'h0);
        check_all("post_rst", 1, 32'h1, 1'b1, 8'h55);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
